// File: rtl/ahb_arbiter.sv
// ahb_arbiter: round-robin AHB arbiter for 2..4 masters.
// Drives a one-hot grant, the address-phase owner (hmaster), the data-phase
// owner (hmaster_data) and hmastlock. Bursts and locked sequences are never
// broken. With no requests the bus parks on master 0.
// Optional feature macro: AHB_ARB_TIMEOUT_EN. When defined, an owner holding
// the bus with a BUSY/SEQ burst while others wait is preempted after MAX_HOLD
// hready cycles. Locked sequences are never preempted.
module ahb_arbiter #(
    parameter int unsigned NUM_MASTERS = 4,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic                   hclk,
    input  logic                   hreset,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [NUM_MASTERS-1:0] hlock,
    input  logic [1:0]             htrans,
    input  logic                   hready,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [1:0]             hmaster,
    output logic [1:0]             hmaster_data,
    output logic                   hmastlock
);

    localparam int unsigned IDX_W = 2;
    localparam int unsigned PAD_W = 4;
    localparam logic [1:0]  HTRANS_BUSY = 2'b01;
    localparam logic [1:0]  HTRANS_SEQ  = 2'b11;

    // Reject configurations the index width and hold counter cannot represent
    if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_num_masters
        $error("ahb_arbiter: NUM_MASTERS must be 2..4");
    end
    if (MAX_HOLD < 2 || MAX_HOLD > 32) begin : g_bad_max_hold
        $error("ahb_arbiter: MAX_HOLD must be 2..32");
    end

    logic [IDX_W-1:0] gnt_idx;
    logic [PAD_W-1:0] req_pad_c;
    logic [PAD_W-1:0] lock_pad_c;
    logic             lock_hold_c;
    logic             burst_hold_c;
    logic             burst_hold_eff_c;
    logic             arb_c;
    logic [IDX_W-1:0] winner_c;
    logic [IDX_W-1:0] cand_c;
    logic             found_c;

    // Widen request/lock vectors so a 2-bit index is always in range
    always_comb begin
        req_pad_c  = PAD_W'(hbusreq);
        lock_pad_c = PAD_W'(hlock);
    end

    // Hold terms: locked ownership vs. an unfinished burst
    always_comb begin
        lock_hold_c  = hmastlock | lock_pad_c[gnt_idx];
        burst_hold_c = (htrans == HTRANS_BUSY) || (htrans == HTRANS_SEQ);
    end

`ifdef AHB_ARB_TIMEOUT_EN
    localparam int unsigned CNT_W = 5;

    logic [CNT_W-1:0] hold_cnt;
    logic             others_req_c;
    logic             timeout_c;

    // Another master is waiting while the owner keeps the bus
    always_comb begin
        others_req_c = |(req_pad_c & ~(PAD_W'(1) << gnt_idx));
        timeout_c    = (hold_cnt == CNT_W'(MAX_HOLD - 1));
    end

    // Count hready cycles of contended ownership; clear on every arbitration
    always_ff @(posedge hclk) begin
        if (hreset) begin
            hold_cnt <= '0;
        end else if (hready) begin
            if (arb_c) begin
                hold_cnt <= '0;
            end else if (others_req_c && (lock_hold_c || burst_hold_c) && !timeout_c) begin
                hold_cnt <= hold_cnt + CNT_W'(1);
            end
        end
    end

    // Timeout can only break a burst, never a lock
    always_comb begin
        burst_hold_eff_c = burst_hold_c & ~timeout_c;
    end
`else
    // Bursts hold the bus for as long as they last
    always_comb begin
        burst_hold_eff_c = burst_hold_c;
    end
`endif

    // Arbitrate only on a completed transfer with no hold in force
    always_comb begin
        arb_c = hready & ~(lock_hold_c | burst_hold_eff_c);
    end

    // Round-robin search starting after the owner; the owner is checked last
    always_comb begin
        winner_c = '0;
        cand_c   = '0;
        found_c  = 1'b0;
        for (int i = 1; i <= int'(NUM_MASTERS); i++) begin
            cand_c = IDX_W'((int'(gnt_idx) + i) % int'(NUM_MASTERS));
            if (!found_c && req_pad_c[cand_c]) begin
                winner_c = cand_c;
                found_c  = 1'b1;
            end
        end
    end

    // Grant, address-phase and data-phase ownership pipeline
    always_ff @(posedge hclk) begin
        if (hreset) begin
            gnt_idx      <= '0;
            hgrant       <= NUM_MASTERS'(1);
            hmaster      <= '0;
            hmaster_data <= '0;
            hmastlock    <= 1'b0;
        end else if (hready) begin
            if (arb_c) begin
                gnt_idx <= winner_c;
                hgrant  <= NUM_MASTERS'(1) << winner_c;
            end
            hmaster      <= gnt_idx;
            hmastlock    <= lock_pad_c[gnt_idx];
            hmaster_data <= hmaster;
        end
    end

endmodule
